// File: rtl/sparc_exu_ecc_pipe.sv
// SEC-DED ECC engine for the EXU write/read paths: generates check bits or checks
// stored ones, with one or two register stages, valid/ready flow control and CE/UE counters.
module sparc_exu_ecc_pipe #(
  parameter int DATA_W = 64,
  parameter int ECC_W  = 8,
  parameter int PIPE   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ECC_W-1:0]  in_ecc,
  input  logic [ECC_W-1:0]  in_msk,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_mode,
  output logic [ECC_W-1:0]  out_ecc,
  output logic [ECC_W-1:0]  out_syn,
  output logic              out_ce,
  output logic              out_ue,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt
);

  localparam int NB = DATA_W / 8;
  localparam int HW = ECC_W - 1;

  typedef logic [ECC_W-1:0][DATA_W-1:0] hmat_t;
  typedef logic [ECC_W-1:0][NB-1:0]     part_t;

  // Row k selects the data bits feeding check bit k; the top row folds the Hamming
  // bits into overall parity so every check bit is a plain XOR over data.
  function automatic hmat_t build_h();
    hmat_t h;
    int    pos;
    logic  par;
    h   = '0;
    pos = 0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = pos + 1;
      while ((pos & (pos - 1)) == 0) pos = pos + 1;
      par = 1'b1;
      for (int k = 0; k < HW; k++) begin
        h[k][i] = pos[k];
        par     = par ^ pos[k];
      end
      h[HW][i] = par;
    end
    return h;
  endfunction

  localparam hmat_t H = build_h();

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("sparc_exu_ecc_pipe: PIPE must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 120) begin : g_bad_data_w
    $error("sparc_exu_ecc_pipe: DATA_W must be a multiple of 8 in 8..120");
  end
  if ((1 << (ECC_W - 1)) < (DATA_W + ECC_W) || (1 << (ECC_W - 2)) >= (DATA_W + ECC_W - 1))
  begin : g_bad_ecc_w
    $error("sparc_exu_ecc_pipe: ECC_W is not the minimal SEC-DED width for DATA_W");
  end

  // Handshake: a stage takes a new word when it is empty or its successor is ready;
  // a word moves on a cycle where both its valid and the receiver's ready are high.
  part_t part_c;
  always_comb begin
    part_c = '0;
    for (int k = 0; k < ECC_W; k++)
      for (int b = 0; b < NB; b++)
        part_c[k][b] = ^(in_data[8*b +: 8] & H[k][8*b +: 8]);
  end

  logic             o_rdy;
  logic             f_vld, f_mode;
  logic [ECC_W-1:0] f_ecc, f_msk;
  part_t            f_part;

  assign o_rdy = !out_vld || out_rdy;

  if (PIPE == 2) begin : g_s1
    logic             s1_vld_q, s1_vld_d, s1_mode_q, s1_mode_d, s1_rdy;
    logic [ECC_W-1:0] s1_ecc_q, s1_ecc_d, s1_msk_q, s1_msk_d;
    part_t            s1_part_q, s1_part_d;

    assign s1_rdy = !s1_vld_q || o_rdy;

    always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_mode_d = s1_mode_q;
      s1_ecc_d  = s1_ecc_q;
      s1_msk_d  = s1_msk_q;
      s1_part_d = s1_part_q;
      if (s1_rdy) begin
        s1_vld_d = in_vld;
        if (in_vld) begin
          s1_mode_d = in_mode;
          s1_ecc_d  = in_ecc;
          s1_msk_d  = in_msk;
          s1_part_d = part_c;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        s1_vld_q  <= 1'b0;
        s1_mode_q <= 1'b0;
        s1_ecc_q  <= '0;
        s1_msk_q  <= '0;
        s1_part_q <= '0;
      end else begin
        s1_vld_q  <= s1_vld_d;
        s1_mode_q <= s1_mode_d;
        s1_ecc_q  <= s1_ecc_d;
        s1_msk_q  <= s1_msk_d;
        s1_part_q <= s1_part_d;
      end
    end

    assign in_rdy = s1_rdy;
    assign f_vld  = s1_vld_q;
    assign f_mode = s1_mode_q;
    assign f_ecc  = s1_ecc_q;
    assign f_msk  = s1_msk_q;
    assign f_part = s1_part_q;
  end else begin : g_s0
    assign in_rdy = o_rdy;
    assign f_vld  = in_vld;
    assign f_mode = in_mode;
    assign f_ecc  = in_ecc;
    assign f_msk  = in_msk;
    assign f_part = part_c;
  end

  logic [ECC_W-1:0] ecc_c, syn_c;
  logic             ce_c, ue_c;
  always_comb begin
    ecc_c = '0;
    for (int k = 0; k < ECC_W; k++) ecc_c[k] = ^f_part[k];
    ecc_c = ecc_c ^ f_msk;
    syn_c = f_mode ? (f_ecc ^ ecc_c) : '0;
    ce_c  = syn_c[HW];
    ue_c  = !syn_c[HW] && (syn_c[HW-1:0] != '0);
  end

  logic             out_vld_q, out_vld_d, out_mode_q, out_mode_d;
  logic             out_ce_q, out_ce_d, out_ue_q, out_ue_d;
  logic [ECC_W-1:0] out_ecc_q, out_ecc_d, out_syn_q, out_syn_d;
  logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_mode_d = out_mode_q;
    out_ecc_d  = out_ecc_q;
    out_syn_d  = out_syn_q;
    out_ce_d   = out_ce_q;
    out_ue_d   = out_ue_q;
    if (o_rdy) begin
      out_vld_d = f_vld;
      if (f_vld) begin
        out_mode_d = f_mode;
        out_ecc_d  = ecc_c;
        out_syn_d  = syn_c;
        out_ce_d   = ce_c;
        out_ue_d   = ue_c;
      end
    end
  end

  // Clear beats a same-cycle increment; increments stop at all-ones.
  always_comb begin
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (cnt_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else begin
      if (out_vld_q && out_rdy && out_ce_q && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + CNT_W'(1);
      if (out_vld_q && out_rdy && out_ue_q && ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_vld_q  <= 1'b0;
      out_mode_q <= 1'b0;
      out_ecc_q  <= '0;
      out_syn_q  <= '0;
      out_ce_q   <= 1'b0;
      out_ue_q   <= 1'b0;
      ce_cnt_q   <= '0;
      ue_cnt_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_mode_q <= out_mode_d;
      out_ecc_q  <= out_ecc_d;
      out_syn_q  <= out_syn_d;
      out_ce_q   <= out_ce_d;
      out_ue_q   <= out_ue_d;
      ce_cnt_q   <= ce_cnt_d;
      ue_cnt_q   <= ue_cnt_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_mode = out_mode_q;
  assign out_ecc  = out_ecc_q;
  assign out_syn  = out_syn_q;
  assign out_ce   = out_ce_q;
  assign out_ue   = out_ue_q;
  assign ce_cnt   = ce_cnt_q;
  assign ue_cnt   = ue_cnt_q;

endmodule

// File: doc/sparc_exu_ecc_pipe.md
Name: sparc_exu_ecc_pipe

Overview:
Parametrised, pipelined SEC-DED ECC engine for the EXU bypass/register-file write and read paths. It has two modes:
- generate: produces ECC_W check bits for a DATA_W data word.
- check: compares regenerated check bits against supplied check bits and reports the syndrome with correctable/uncorrectable flags.

Pipeline depth (1 or 2 register stages) is selectable. Valid/ready flow control allows stalls. A per-word mask provides error injection. Saturating counters track CE and UE events.

Parameters:
DATA_W, 64, data width; 8 <= DATA_W <= 120, multiple of 8.
ECC_W, 8, check-bit width; smallest value with 2^(ECC_W-1) >= DATA_W+ECC_W. Bit ECC_W-1 is overall parity; bits [ECC_W-2:0] are Hamming bits.
PIPE, 2, register stages, 1 or 2; any other value is an elaboration error.
CNT_W, 16, width of the CE/UE counters.

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
in_vld  in  1  input word valid
in_rdy  out  1  engine can accept this cycle
in_mode  in  1  0 = generate, 1 = check
in_data  in  DATA_W  data word
in_ecc  in  ECC_W  stored check bits (check mode only)
in_msk  in  ECC_W  injection mask, XORed into generated check bits
out_vld  out  1  result valid
out_rdy  in  1  downstream accepts result
out_mode  out  1  mode of the result word
out_ecc  out  ECC_W  generated check bits (masked)
out_syn  out  ECC_W  in_ecc ^ out_ecc; zero in generate mode
out_ce  out  1  single-bit (correctable) error; check mode only
out_ue  out  1  multi-bit (uncorrectable) error; check mode only
cnt_clr  in  1  synchronous clear of both counters
ce_cnt  out  CNT_W  saturating count of accepted out_ce results
ue_cnt  out  CNT_W  saturating count of accepted out_ue results

Behaviour:
- Reset (rst_l low, asynchronous):
  - All stage valids clear; out_vld = 0.
  - out_ecc, out_syn, out_ce, out_ue, out_mode = 0; ce_cnt = ue_cnt = 0.
  - Reset asserted mid-operation discards all in-flight words. There is no output glitch after release.
- Code definition:
  - Data bit i occupies the (i+1)-th non-power-of-two position, 1-based (d[0] -> position 3, d[1] -> 5, d[2] -> 6, d[3] -> 7, d[4] -> 9, ...).
  - Hamming bit k = XOR of data bits whose position has bit k set.
  - Overall bit = XOR of all data bits and all Hamming bits.
  - gen = {overall, hamming}; out_ecc = gen ^ msk.
- Check mode:
  - syn = in_ecc ^ out_ecc.
  - ce = syn[ECC_W-1].
  - ue = !syn[ECC_W-1] && (syn[ECC_W-2:0] != 0).
  - syn == 0 gives no error.
  - In generate mode out_syn, out_ce and out_ue are forced to 0.
- Pipeline:
  - Stage k valid v[k]; rdy[k] = !v[k] || rdy[k+1]; rdy[last+1] = out_rdy; in_rdy = rdy[1] (combinational from out_rdy).
  - Word accepted when in_vld && in_rdy.
  - A stage loads when its ready is high and holds when its ready is low; data and flags are never lost or duplicated.
- PIPE=2:
  - Stage 1 registers, per check bit, DATA_W/8 partial parities (one per data byte), plus msk, mode and in_ecc.
  - Stage 2 reduces the partials, applies the mask, computes syn/ce/ue and registers the outputs.
- PIPE=1: full computation feeds a single output register.
- Latency: PIPE cycles from acceptance to out_vld with out_rdy held high. Throughput is 1 word per cycle.
- Outputs are stable while out_vld && !out_rdy.
- Counters:
  - Increment on out_vld && out_rdy && out_ce (respectively out_ue).
  - Saturate at 2^CNT_W-1.
  - cnt_clr takes priority over an increment in the same cycle; the counter reads 0 next cycle.
- Simultaneous accept at input and output with a full pipe is legal and sustains full rate.

Test Plan:
1. Generate, DATA_W=64, PIPE=2, in_data=0, msk=0 -> out_vld 2 cycles later, out_ecc=0x00, out_syn=0.
2. Generate, in_data=64'h1, msk=0 -> out_ecc=0x83. Same data with msk=0x01 -> out_ecc=0x82.
3. Check, in_data=0, in_ecc=0x83 -> out_syn=0x83, out_ce=1, out_ue=0, ce_cnt=1. Then in_ecc=0x03 -> out_syn=0x03, out_ue=1, ue_cnt=1.
4. Backpressure: stream 6 words with out_rdy low for 4 cycles mid-stream.
   - in_rdy drops once 2 words are held.
   - All 6 results emerge in order, unchanged, no duplicates.
   - Full 1-word/cycle rate when out_rdy is high.
5. Assert rst_l low with 2 words in flight -> out_vld=0 immediately and counters 0. After release, the first new word appears with correct latency.
6. Counter behaviour:
   - With CNT_W=2, feed 5 CE words -> ce_cnt saturates at 3.
   - cnt_clr in the same cycle as a CE acceptance -> ce_cnt=0.
   - PIPE=1 rerun of scenario 1 -> latency 1.
